maxpool_seq: RTL
================

# maxpool_seq

Streaming sequencer for the 2x2, stride-2 max-pool stage of the CNN accelerator. It accepts one feature-map pixel per handshake in raster order and holds partial maxima from the even rows in an internal line buffer. It emits one pooled value per 2x2 window in raster order, with valid/ready on both sides. It sits between the convolution output stream and the next layer's input buffer, and replaces the fixed-size combinational pool.

## Interface
- DATA_W, 4: pixel and result width, unsigned.
- IMG_W, 6: input feature-map width in pixels. Must be even and ≥2.
- IMG_H, 6: input feature-map height in pixels. Must be even and ≥2.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle frame start request. Honoured only in IDLE.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the final output handshake.
- in_valid  input  1  input pixel valid.
- in_ready  output  1  block can accept a pixel.
- in_data  input  DATA_W  input pixel.
- out_valid  output  1  pooled result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_W  pooled result.
- out_last  output  1  high together with the final result of the frame.

## Operation
- States: IDLE, RUN, FLUSH.
  - IDLE→RUN on start. This clears the row and column counters.
  - RUN→FLUSH when the last pixel, (IMG_H-1, IMG_W-1), is accepted.
  - FLUSH→IDLE when the final result is accepted. done pulses on this transition.
- Counters: col runs 0..IMG_W-1 and row runs 0..IMG_H-1. col advances on each input handshake; at IMG_W-1 it wraps to 0 and row increments.
- Even col: the pixel is latched into the pair register.
- Odd col: pairmax = max(pair, in_data), using an unsigned compare. Equal values give that value.
  - Even row: linebuf[col>>1] ← pairmax. The line buffer has IMG_W/2 entries of DATA_W bits.
  - Odd row: the result register ← max(linebuf[col>>1], pairmax), and out_valid is set.
  - out_last is set when this is the final window.
- The output register is a single entry.
  - out_valid stays high, with out_data and out_last stable, until out_ready is sampled high.
  - On that handshake, out_valid clears unless a new result loads in the same cycle.
- in_ready = (state==RUN) && !(row odd && col odd && out_valid && !out_ready).
  - Even rows never stall.
  - An odd-row, odd-col pixel stalls only while an unaccepted result is pending.
  - If a result handshake and a new result load happen in the same cycle, the load wins: out_valid stays 1 and the new data appears.
- A start received in RUN or FLUSH is ignored.
- in_valid and in_data are ignored whenever in_ready is low.
- rst_n low at any time, including mid-frame, forces:
  - state IDLE, counters 0;
  - out_valid=0, out_data=0, out_last=0, busy=0, done=0, in_ready=0.
- Line buffer contents are not reset. They are always written before they are read.

## Timing
- Reset values: every output is 0.
- in_ready rises the cycle after start is accepted in IDLE, together with busy.
- Latency: out_valid rises the cycle after the odd-row, odd-col pixel handshake, i.e. one register stage.
- Throughput: 1 pixel/cycle when out_ready is held high. No bubbles occur at row or frame wrap inside a frame.
- done pulses 1 cycle after the handshake where out_last=1.
  - busy falls in that same cycle.
  - The block can accept a new start in the cycle done is high; busy rises the next cycle.
- A frame of IMG_W×IMG_H pixels yields exactly (IMG_W/2)×(IMG_H/2) results.

## Test plan
- Ramp, 6×6 input, pixel = row+col, out_ready=1 → 9 results in order 2,4,6,4,6,8,6,8,10. out_last only on the 10. done 1 cycle after the 10 is accepted.
- Single hot pixel: 15 at (3,4), all other pixels 0 → results 0,0,0,0,0,15,0,0,0.
- Backpressure: out_ready low for 5 cycles after the first result → out_data stays 2 and out_valid stays high. in_ready is low only when the (1,3) pixel is presented. Final sequence is identical to the ramp case, with no loss or duplication.
- Ties and extremes: all pixels 15, then all pixels 7 → nine 15s, then nine 7s. Frames run back-to-back by pulsing start in the done cycle.
- start pulsed mid-RUN → ignored; counters and output sequence are unchanged.
- rst_n low after 20 pixels → all outputs 0 immediately. A subsequent start plus a full ramp frame reproduces the ramp results exactly.

Source files
------------

// File: rtl/maxpool_seq.sv
// 2x2 stride-2 streaming max-pool: raster-order pixels in, one pooled value per window out.
// Even rows leave pair maxima in a line buffer; odd rows combine them into a single-entry output register.
module maxpool_seq #(
    parameter int DATA_W = 4,
    parameter int IMG_W  = 6,
    parameter int IMG_H  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LN = IMG_W / 2;
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] pair_q, pair_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] linebuf_q [LN];

    logic              in_fire, out_fire, last_pix, res_load, lb_we;
    logic [CW-1:0]     col_half;
    logic [LW-1:0]     lb_idx;
    logic [DATA_W-1:0] pairmax, lb_rd, winmax;

    // Handshakes: a transfer occurs on a rising edge where valid and ready are both high.
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign last_pix = (row_q == ROW_MAX) && (col_q == COL_MAX);

    assign col_half = col_q >> 1;
    assign lb_idx   = col_half[LW-1:0];
    assign lb_rd    = linebuf_q[lb_idx];
    assign pairmax  = (in_data > pair_q) ? in_data : pair_q;
    assign winmax   = (lb_rd > pairmax) ? lb_rd : pairmax;
    assign res_load = in_fire && row_q[0] && col_q[0];
    assign lb_we    = in_fire && !row_q[0] && col_q[0];

    // State register (also holds the registered done pulse).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (in_fire && last_pix) state_d = S_FLUSH;
            S_FLUSH: if (out_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs. Only the odd-row, odd-col pixel can be blocked by a pending result.
    always_comb begin
        busy     = (state_q != S_IDLE);
        in_ready = (state_q == S_RUN) &&
                   !(row_q[0] && col_q[0] && out_valid_q && !out_ready);
        done_d   = (state_q == S_FLUSH) && out_fire;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == S_IDLE && start) begin
            col_d = '0;
            row_d = '0;
        end else if (in_fire) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // A new result loading in the same cycle as a handshake keeps out_valid high.
    always_comb begin
        pair_d      = (in_fire && !col_q[0]) ? in_data : pair_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (res_load) begin
            out_valid_d = 1'b1;
            out_data_d  = winmax;
            out_last_d  = last_pix;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Line buffer is written on every even row before the odd row reads it, so no reset.
    always_ff @(posedge clk) begin
        if (lb_we) linebuf_q[lb_idx] <= pairmax;
    end

    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule
